// File: rtl/sim_uart_xcvr.sv
// 8N1 UART transceiver, 16x oversampled timing from a run-time divisor.
// Host-side parallel byte interface; TX and RX run fully independently.
module sim_uart_xcvr #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned SYNC  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] divisor_i,
    input  logic             uart_rx_i,
    output logic             uart_tx_o,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_write_i,
    output logic             tx_busy_o,
    output logic             tx_done_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_done_o,
    output logic             rx_frame_err_o
);

    localparam int unsigned CNT_W = DIV_W + 4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;

    // Bit period = 16*D clocks, with a zero divisor treated as 1
    logic [DIV_W-1:0] div_eff_c;
    logic [CNT_W-1:0] bit_len_c;
    assign div_eff_c = (divisor_i == '0) ? DIV_W'(1) : divisor_i;
    assign bit_len_c = {div_eff_c, 4'b0000};

    tx_state_t        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [CNT_W-1:0] tx_len_q;
    logic [7:0]       tx_shift_q;
    logic [2:0]       tx_bit_q;
    logic             uart_tx_q;
    logic             tx_busy_q;
    logic             tx_done_q;

    // START runs one extra cycle so the line drops the cycle after acceptance
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_len_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            uart_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_write_i && !tx_busy_q) begin
                        tx_shift_q <= tx_data_i;
                        tx_len_q   <= bit_len_c;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_busy_q  <= 1'b1;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    uart_tx_q <= 1'b0;
                    if (tx_cnt_q == tx_len_q) begin
                        tx_cnt_q   <= '0;
                        uart_tx_q  <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == tx_len_q - CNT_W'(1)) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            uart_tx_q  <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            uart_tx_q  <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == tx_len_q - CNT_W'(1)) begin
                        tx_cnt_q   <= '0;
                        tx_busy_q  <= 1'b0;
                        tx_done_q  <= 1'b1;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    logic [SYNC-1:0] rx_sync_q;
    logic            rx_s;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rx_sync_q <= '1;
        else        rx_sync_q <= {rx_sync_q[SYNC-2:0], uart_rx_i};
    end
    assign rx_s = rx_sync_q[SYNC-1];

    rx_state_t        rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [CNT_W-1:0] rx_len_q;
    logic [7:0]       rx_shift_q;
    logic [2:0]       rx_bit_q;
    logic             rx_prev_q;
    logic [7:0]       rx_data_q;
    logic             rx_done_q;
    logic             rx_err_q;

    // Mid-bit sampling: first sample at half a bit, then every full bit
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_len_q   <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_prev_q  <= 1'b1;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            rx_done_q <= 1'b0;
            rx_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        rx_cnt_q   <= '0;
                        rx_len_q   <= bit_len_c;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == (rx_len_q >> 1) - CNT_W'(1)) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == rx_len_q - CNT_W'(1)) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == rx_len_q - CNT_W'(1)) begin
                        rx_cnt_q <= '0;
                        if (rx_s) begin
                            rx_data_q  <= rx_shift_q;
                            rx_done_q  <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_err_q   <= 1'b1;
                            rx_state_q <= RX_WAIT_HI;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_WAIT_HI: begin
                    if (rx_s) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign uart_tx_o      = uart_tx_q;
    assign tx_busy_o      = tx_busy_q;
    assign tx_done_o      = tx_done_q;
    assign rx_data_o      = rx_data_q;
    assign rx_done_o      = rx_done_q;
    assign rx_frame_err_o = rx_err_q;

endmodule

// File: tb/tb_sim_uart_xcvr.sv
// Directed bench for sim_uart_xcvr: reset, TX framing/timing, RX, glitch,
// framing error, TX write acceptance at frame end, loopback and mid-frame reset.
module tb_sim_uart_xcvr;

    logic        clk_i;
    logic        rst_i;
    logic [15:0] divisor_i;
    logic        rx_drive;
    logic        loop_en;
    logic        rx_line;
    logic        uart_tx_o;
    logic [7:0]  tx_data_i;
    logic        tx_write_i;
    logic        tx_busy_o;
    logic        tx_done_o;
    logic [7:0]  rx_data_o;
    logic        rx_done_o;
    logic        rx_frame_err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int tx_done_cnt = 0;
    int rx_done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] rx_last = 8'h00;

    assign rx_line = loop_en ? uart_tx_o : rx_drive;

    sim_uart_xcvr #(.DIV_W(16), .SYNC(2)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .divisor_i      (divisor_i),
        .uart_rx_i      (rx_line),
        .uart_tx_o      (uart_tx_o),
        .tx_data_i      (tx_data_i),
        .tx_write_i     (tx_write_i),
        .tx_busy_o      (tx_busy_o),
        .tx_done_o      (tx_done_o),
        .rx_data_o      (rx_data_o),
        .rx_done_o      (rx_done_o),
        .rx_frame_err_o (rx_frame_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Pulse monitors, sampled away from the active edge
    always @(negedge clk_i) begin
        if (tx_done_o) tx_done_cnt++;
        if (rx_done_o) begin
            rx_done_cnt++;
            rx_last = rx_data_o;
        end
        if (rx_frame_err_o) err_cnt++;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_clks);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drive = fr[k];
            repeat (bit_clks) @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; tx_write_i = 1'b0; tx_data_i = 8'h00; divisor_i = 16'd43;
        rx_drive = 1'b1; loop_en = 1'b0;
        repeat (5) @(negedge clk_i);
        n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL rst_tx: got %b want 1", uart_tx_o); end
        n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", tx_busy_o); end
        n_cmp++; if (tx_done_o !== 1'b0) begin n_bad++; $display("FAIL rst_txdone: got %b want 0", tx_done_o); end
        n_cmp++; if (rx_data_o !== 8'h00) begin n_bad++; $display("FAIL rst_rxdata: got %h want 00", rx_data_o); end
        n_cmp++; if (rx_done_o !== 1'b0) begin n_bad++; $display("FAIL rst_rxdone: got %b want 0", rx_done_o); end
        n_cmp++; if (rx_frame_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", rx_frame_err_o); end
        rst_i = 1'b1;
        repeat (1000) @(negedge clk_i);
        n_cmp++; if (tx_done_cnt !== 0) begin n_bad++; $display("FAIL idle_txdone: got %0d want 0", tx_done_cnt); end
        n_cmp++; if (rx_done_cnt !== 0) begin n_bad++; $display("FAIL idle_rxdone: got %0d want 0", rx_done_cnt); end
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL idle_err: got %0d want 0", err_cnt); end
        n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL idle_tx: got %b want 1", uart_tx_o); end
    endtask

    // 0xA5 at D=43: 10 bits of 688 clocks, done at 6881 clocks after acceptance
    task automatic test_tx_a5();
        logic [9:0] fr;
        int base;
        int k;
        int r;
        fr = {1'b1, 8'hA5, 1'b0};
        base = tx_done_cnt;
        tx_data_i = 8'hA5; tx_write_i = 1'b1;
        for (int i = 1; i <= 6890; i++) begin
            @(negedge clk_i);
            if (i == 1) begin
                tx_write_i = 1'b0;
                n_cmp++; if (tx_busy_o !== 1'b1) begin n_bad++; $display("FAIL tx_busy_set: got %b want 1", tx_busy_o); end
                n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL tx_pre_start: got %b want 1", uart_tx_o); end
            end
            if (i == 1000) begin tx_data_i = 8'h00; tx_write_i = 1'b1; end
            if (i == 1001) tx_write_i = 1'b0;
            if (i == 2000) divisor_i = 16'd5;
            if (i >= 2 && i <= 6881) begin
                k = (i - 2) / 688;
                r = (i - 2) % 688;
                if (r == 0 || r == 687) begin
                    n_cmp++; if (uart_tx_o !== fr[k]) begin n_bad++; $display("FAIL tx_bit%0d_off%0d: got %b want %b", k, r, uart_tx_o, fr[k]); end
                end
            end
            if (i == 6881) begin
                n_cmp++; if (tx_done_o !== 1'b0) begin n_bad++; $display("FAIL tx_done_early: got %b want 0", tx_done_o); end
                n_cmp++; if (tx_busy_o !== 1'b1) begin n_bad++; $display("FAIL tx_busy_hold: got %b want 1", tx_busy_o); end
            end
            if (i == 6882) begin
                n_cmp++; if (tx_done_o !== 1'b1) begin n_bad++; $display("FAIL tx_done_pulse: got %b want 1", tx_done_o); end
                n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL tx_busy_clr: got %b want 0", tx_busy_o); end
            end
            if (i == 6883) begin
                n_cmp++; if (tx_done_o !== 1'b0) begin n_bad++; $display("FAIL tx_done_width: got %b want 0", tx_done_o); end
            end
        end
        divisor_i = 16'd43;
        n_cmp++; if (tx_done_cnt !== base + 1) begin n_bad++; $display("FAIL tx_done_count: got %0d want %0d", tx_done_cnt, base + 1); end
    endtask

    task automatic test_rx();
        int base;
        base = rx_done_cnt;
        send_frame(8'h3C, 1'b1, 688);
        n_cmp++; if (rx_done_cnt !== base + 1) begin n_bad++; $display("FAIL rx1_count: got %0d want %0d", rx_done_cnt, base + 1); end
        n_cmp++; if (rx_last !== 8'h3C) begin n_bad++; $display("FAIL rx1_data: got %h want 3c", rx_last); end
        send_frame(8'h00, 1'b1, 688);
        n_cmp++; if (rx_done_cnt !== base + 2) begin n_bad++; $display("FAIL rx2_count: got %0d want %0d", rx_done_cnt, base + 2); end
        n_cmp++; if (rx_last !== 8'h00) begin n_bad++; $display("FAIL rx2_data: got %h want 00", rx_last); end
        n_cmp++; if (rx_data_o !== 8'h00) begin n_bad++; $display("FAIL rx2_hold: got %h want 00", rx_data_o); end
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL rx_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_glitch();
        int base_d;
        int base_e;
        base_d = rx_done_cnt; base_e = err_cnt;
        rx_drive = 1'b0;
        repeat (100) @(negedge clk_i);
        rx_drive = 1'b1;
        repeat (1000) @(negedge clk_i);
        n_cmp++; if (rx_done_cnt !== base_d) begin n_bad++; $display("FAIL glitch_done: got %0d want %0d", rx_done_cnt, base_d); end
        n_cmp++; if (err_cnt !== base_e) begin n_bad++; $display("FAIL glitch_err: got %0d want %0d", err_cnt, base_e); end
        send_frame(8'h5A, 1'b1, 688);
        n_cmp++; if (rx_done_cnt !== base_d + 1) begin n_bad++; $display("FAIL glitch_next_count: got %0d want %0d", rx_done_cnt, base_d + 1); end
        n_cmp++; if (rx_last !== 8'h5A) begin n_bad++; $display("FAIL glitch_next_data: got %h want 5a", rx_last); end
    endtask

    task automatic test_framing();
        int base_d;
        int base_e;
        base_d = rx_done_cnt; base_e = err_cnt;
        send_frame(8'h55, 1'b0, 688);
        repeat (2000) @(negedge clk_i);
        n_cmp++; if (err_cnt !== base_e + 1) begin n_bad++; $display("FAIL ferr_count: got %0d want %0d", err_cnt, base_e + 1); end
        n_cmp++; if (rx_done_cnt !== base_d) begin n_bad++; $display("FAIL ferr_done: got %0d want %0d", rx_done_cnt, base_d); end
        n_cmp++; if (rx_data_o !== 8'h5A) begin n_bad++; $display("FAIL ferr_hold: got %h want 5a", rx_data_o); end
        rx_drive = 1'b1;
        repeat (100) @(negedge clk_i);
        send_frame(8'hC3, 1'b1, 688);
        n_cmp++; if (rx_done_cnt !== base_d + 1) begin n_bad++; $display("FAIL ferr_next_count: got %0d want %0d", rx_done_cnt, base_d + 1); end
        n_cmp++; if (rx_data_o !== 8'hC3) begin n_bad++; $display("FAIL ferr_next_data: got %h want c3", rx_data_o); end
        n_cmp++; if (err_cnt !== base_e + 1) begin n_bad++; $display("FAIL ferr_next_err: got %0d want %0d", err_cnt, base_e + 1); end
    endtask

    // D=1: write held over the done edge is dropped, the next cycle's write starts 0x69
    task automatic test_back_to_back();
        logic [9:0] fr;
        int k;
        fr = {1'b1, 8'h69, 1'b0};
        divisor_i = 16'd1;
        tx_data_i = 8'h96; tx_write_i = 1'b1;
        for (int i = 1; i <= 330; i++) begin
            @(negedge clk_i);
            if (i == 1) tx_write_i = 1'b0;
            if (i == 161) begin tx_data_i = 8'h3C; tx_write_i = 1'b1; end
            if (i == 162) begin
                n_cmp++; if (tx_done_o !== 1'b1) begin n_bad++; $display("FAIL b2b_done1: got %b want 1", tx_done_o); end
                n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL b2b_drop: got %b want 0", tx_busy_o); end
                tx_data_i = 8'h69;
            end
            if (i == 163) begin
                tx_write_i = 1'b0;
                n_cmp++; if (tx_busy_o !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got %b want 1", tx_busy_o); end
            end
            if (i >= 172 && i <= 316 && ((i - 172) % 16) == 0) begin
                k = (i - 172) / 16;
                n_cmp++; if (uart_tx_o !== fr[k]) begin n_bad++; $display("FAIL b2b_bit%0d: got %b want %b", k, uart_tx_o, fr[k]); end
            end
            if (i == 324) begin
                n_cmp++; if (tx_done_o !== 1'b1) begin n_bad++; $display("FAIL b2b_done2: got %b want 1", tx_done_o); end
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        int dv [2];
        int base_r;
        int base_e;
        int t_done;
        bytes = '{8'h00, 8'hFF, 8'h81};
        dv = '{1, 0};
        loop_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            divisor_i = 16'(dv[d]);
            for (int b = 0; b < 3; b++) begin
                base_r = rx_done_cnt; base_e = err_cnt; t_done = 0;
                tx_data_i = bytes[b]; tx_write_i = 1'b1;
                for (int i = 1; i <= 400; i++) begin
                    @(negedge clk_i);
                    if (i == 1) tx_write_i = 1'b0;
                    if (tx_done_o && t_done == 0) t_done = i;
                end
                n_cmp++; if (t_done !== 162) begin n_bad++; $display("FAIL lb_d%0d_b%0d_latency: got %0d want 162", dv[d], b, t_done); end
                n_cmp++; if (rx_done_cnt !== base_r + 1) begin n_bad++; $display("FAIL lb_d%0d_b%0d_count: got %0d want %0d", dv[d], b, rx_done_cnt, base_r + 1); end
                n_cmp++; if (rx_last !== bytes[b]) begin n_bad++; $display("FAIL lb_d%0d_b%0d_data: got %h want %h", dv[d], b, rx_last, bytes[b]); end
                n_cmp++; if (err_cnt !== base_e) begin n_bad++; $display("FAIL lb_d%0d_b%0d_err: got %0d want %0d", dv[d], b, err_cnt, base_e); end
            end
        end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int base_t;
        int base_r;
        int base_e;
        base_t = tx_done_cnt; base_r = rx_done_cnt; base_e = err_cnt;
        divisor_i = 16'd1;
        tx_data_i = 8'h00; tx_write_i = 1'b1; rx_drive = 1'b0;
        @(negedge clk_i);
        tx_write_i = 1'b0;
        repeat (49) @(negedge clk_i);
        n_cmp++; if (uart_tx_o !== 1'b0) begin n_bad++; $display("FAIL mrst_line_low: got %b want 0", uart_tx_o); end
        rst_i = 1'b0;
        #1;
        n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL mrst_line_high: got %b want 1", uart_tx_o); end
        n_cmp++; if (tx_busy_o !== 1'b0) begin n_bad++; $display("FAIL mrst_busy: got %b want 0", tx_busy_o); end
        n_cmp++; if (rx_data_o !== 8'h00) begin n_bad++; $display("FAIL mrst_rxdata: got %h want 00", rx_data_o); end
        rx_drive = 1'b1;
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (300) @(negedge clk_i);
        n_cmp++; if (tx_done_cnt !== base_t) begin n_bad++; $display("FAIL mrst_txdone: got %0d want %0d", tx_done_cnt, base_t); end
        n_cmp++; if (rx_done_cnt !== base_r) begin n_bad++; $display("FAIL mrst_rxdone: got %0d want %0d", rx_done_cnt, base_r); end
        n_cmp++; if (err_cnt !== base_e) begin n_bad++; $display("FAIL mrst_err: got %0d want %0d", err_cnt, base_e); end
        n_cmp++; if (uart_tx_o !== 1'b1) begin n_bad++; $display("FAIL mrst_idle_tx: got %b want 1", uart_tx_o); end
    endtask

    initial begin
        test_reset();
        test_tx_a5();
        test_rx();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_loopback();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
